core_fetch: RTL and testbench

//  Instruction fetch front-end upstream of core_s1. Issues word fetches to the memory port,

---
 rtl/core_fetch.sv | 133 +++++++++++++
 tb/tb_core_fetch.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_fetch.sv
// Instruction fetch front-end: issues word fetches, queues in-order responses with their PC,
// and hands {pc, instr, fault} downstream. Optional stall counter under CORE_FETCH_PERF_EN.
module core_fetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    input  logic        rsp_fault,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [1:0]  out_fault,
    output logic [31:0] stall_cycles
);
    localparam int              PTR_W   = $clog2(DEPTH);
    localparam int              CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [31:0]      fetch_pc;
    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] fill_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] filled;
    logic             halted;
    logic             misalign_pend;
    logic             req_fire;
    logic             rsp_keep;
    logic             pop;
    logic             redir_misaligned;

    logic [31:0] q_pc    [DEPTH];
    logic [31:0] q_instr [DEPTH];
    logic [1:0]  q_fault [DEPTH];

    // Slots are allocated at issue (wr_ptr), filled by responses (fill_ptr), drained at rd_ptr.
    // Only filled entries count against issue; unfilled slots are already covered by outstanding.
    assign filled           = fill_ptr - rd_ptr;
    assign req_valid        = rst_n && !redirect_valid && !halted
                              && (({1'b0, outstanding} + {1'b0, filled}) < DEPTH_C);
    assign req_addr         = fetch_pc;
    assign req_fire         = req_valid && req_ready;
    assign rsp_keep         = rsp_valid && (discard == '0);
    assign out_valid        = (rd_ptr != fill_ptr);
    assign pop              = out_valid && out_ready;
    assign redir_misaligned = (redirect_pc[1:0] != 2'b00);

    assign out_pc    = q_pc[rd_ptr[PTR_W-1:0]];
    assign out_instr = q_instr[rd_ptr[PTR_W-1:0]];
    assign out_fault = q_fault[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc      <= RESET_PC;
            wr_ptr        <= '0;
            fill_ptr      <= '0;
            rd_ptr        <= '0;
            outstanding   <= '0;
            discard       <= '0;
            halted        <= 1'b0;
            misalign_pend <= 1'b0;
        end else if (redirect_valid) begin
            // Every response still owed after this edge belongs to a squashed request.
            fetch_pc      <= redirect_pc;
            wr_ptr        <= '0;
            fill_ptr      <= '0;
            rd_ptr        <= '0;
            outstanding   <= outstanding - CNT_W'(rsp_valid);
            discard       <= outstanding - CNT_W'(rsp_valid);
            halted        <= redir_misaligned;
            misalign_pend <= redir_misaligned;
        end else begin
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_valid);
            if (rsp_valid && (discard != '0)) begin
                discard <= discard - 1'b1;
            end
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            wr_ptr   <= wr_ptr + CNT_W'(req_fire) + CNT_W'(misalign_pend);
            fill_ptr <= fill_ptr + CNT_W'(rsp_keep) + CNT_W'(misalign_pend);
            rd_ptr   <= rd_ptr + CNT_W'(pop);
            if (rsp_keep && rsp_fault) begin
                halted <= 1'b1;
            end
            misalign_pend <= 1'b0;
        end
    end

    // Queue payload carries no reset; validity comes entirely from the pointers.
    always_ff @(posedge clk) begin
        if (!redirect_valid) begin
            if (misalign_pend) begin
                q_pc[wr_ptr[PTR_W-1:0]]    <= fetch_pc;
                q_instr[wr_ptr[PTR_W-1:0]] <= '0;
                q_fault[wr_ptr[PTR_W-1:0]] <= 2'b10;
            end else if (req_fire) begin
                q_pc[wr_ptr[PTR_W-1:0]] <= fetch_pc;
            end
            if (rsp_keep) begin
                q_instr[fill_ptr[PTR_W-1:0]] <= rsp_fault ? 32'h0 : rsp_data;
                q_fault[fill_ptr[PTR_W-1:0]] <= {1'b0, rsp_fault};
            end
        end
    end

`ifdef CORE_FETCH_PERF_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out_ready && !out_valid && !redirect_valid && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_core_fetch.sv
// Scoreboard bench for core_fetch: memory model answers in order, expected entries are queued
// at request acceptance and compared when the DUT hands them downstream.
module tb_core_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        rsp_fault = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [1:0]  out_fault;
    logic [31:0] stall_cycles;

    core_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_fault(rsp_fault),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_fault(out_fault),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [1:0]  fault;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_q[$];
    logic [31:0] exp_addr = '0;
    int          errs = 0;
    int          checks = 0;
    int          n_req = 0;
    int          n_out = 0;
    int          n_f01 = 0;
    int          n_f10 = 0;
    bit          rdy = 0, rsp_on = 0, ordy = 0, do_redir = 0, fault_on = 0, cap = 0;
    logic [31:0] redir_to = '0;
    logic [31:0] fault_at = '0;
    logic [31:0] first_pc = '0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; handshakes are observed 1 unit later and take
    // effect at the following rising edge.
    task automatic cycle();
        logic [31:0] a;
        exp_t        e;
        bit          f;
        @(negedge clk);
        redirect_valid = do_redir;
        redirect_pc    = redir_to;
        do_redir       = 0;
        req_ready      = rdy;
        out_ready      = ordy;
        if (rsp_on && mem_q.size() > 0) begin
            a         = mem_q.pop_front();
            rsp_valid = 1'b1;
            rsp_data  = instr_of(a);
            rsp_fault = fault_on && (a == fault_at);
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = '0;
            rsp_fault = 1'b0;
        end
        #1;
        if (redirect_valid) begin
            check_eq("redir_noreq", {31'b0, req_valid}, 32'd0);
            exp_q.delete();
            exp_addr = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) exp_q.push_back('{redirect_pc, 32'h0, 2'b10});
        end else begin
            if (req_valid && req_ready) begin
                n_req++;
                check_eq("req_addr", req_addr, exp_addr);
                mem_q.push_back(req_addr);
                f = fault_on && (exp_addr == fault_at);
                exp_q.push_back('{exp_addr, f ? 32'h0 : instr_of(exp_addr), f ? 2'b01 : 2'b00});
                exp_addr = exp_addr + 32'd4;
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (out_fault == 2'b01) n_f01++;
                if (out_fault == 2'b10) n_f10++;
                if (cap) begin
                    first_pc = out_pc;
                    cap      = 0;
                end
                if (exp_q.size() == 0) begin
                    check_eq("out_unexpected", out_pc, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("out_pc", out_pc, e.pc);
                    check_eq("out_instr", out_instr, e.instr);
                    check_eq("out_fault", {30'b0, out_fault}, {30'b0, e.fault});
                end
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Stop issuing, let every response and queued entry drain.
    task automatic quiesce();
        rdy = 0; rsp_on = 1; ordy = 1;
        run(8);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        do_redir = 1;
        redir_to = pc;
        cycle();
    endtask

    initial begin
        logic [31:0] s0;
        logic [31:0] s1;
        int          outs0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_req_valid", {31'b0, req_valid}, 32'd0);
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_stall", stall_cycles, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: sequential fetch from RESET_PC with 1-cycle responses
        rdy = 1; rsp_on = 1; ordy = 1;
        cap = 1;
        run(20);
        check_eq("t1_first_pc", first_pc, 32'h0);
        check_eq("t1_enough_out", {31'b0, n_out >= 10}, 32'd1);

        // 2: responses withheld, consumer stalled -> exactly DEPTH requests
        quiesce();
        rsp_on = 0; ordy = 0; rdy = 1;
        redirect_to(32'h200);
        n_req = 0;
        run(10);
        check_eq("t2_nreq", n_req, 32'd4);
        check_eq("t2_req_low", {31'b0, req_valid}, 32'd0);
        rsp_on = 1; ordy = 1;
        cap = 1;
        run(12);
        check_eq("t2_first_pc", first_pc, 32'h200);

        // 3: three in flight, redirect squashes them
        quiesce();
        redirect_to(32'h40);
        rdy = 1; rsp_on = 0; ordy = 1;
        n_req = 0;
        run(3);
        check_eq("t3_inflight", n_req, 32'd3);
        rsp_on = 1;
        cap = 1;
        redirect_to(32'h100);
        run(15);
        check_eq("t3_first_pc", first_pc, 32'h100);

        // 4: access fault at 0x8 halts fetch
        quiesce();
        fault_on = 1; fault_at = 32'h8;
        redirect_to(32'h0);
        rdy = 1; rsp_on = 1; ordy = 1;
        n_f01 = 0;
        run(15);
        check_eq("t4_fault_seen", n_f01, 32'd1);
        n_req = 0;
        run(8);
        check_eq("t4_halted_nreq", n_req, 32'd0);
        check_eq("t4_req_low", {31'b0, req_valid}, 32'd0);
        quiesce();
        fault_on = 0;

        // 5: misaligned redirect yields a fault entry and halts
        n_f10 = 0;
        rdy = 1; ordy = 1;
        redirect_to(32'h102);
        n_req = 0;
        run(8);
        check_eq("t5_nreq", n_req, 32'd0);
        check_eq("t5_f10_seen", n_f10, 32'd1);
        redirect_to(32'h300);
        cap = 1;
        run(8);
        check_eq("t5_resume_pc", first_pc, 32'h300);

        // 6: starved consumer cycles
        quiesce();
        rdy = 0; ordy = 1;
        run(1);
        s0 = stall_cycles;
        run(10);
        s1 = stall_cycles;
`ifdef CORE_FETCH_PERF_EN
        check_eq("t6_stall_delta", s1 - s0, 32'd10);
`else
        check_eq("t6_stall_zero", s1, 32'd0);
`endif

        // 7: random backpressure, response gaps and occasional redirects
        outs0 = n_out;
        for (int i = 0; i < 300; i++) begin
            rdy    = ($urandom_range(0, 3) != 0);
            rsp_on = ($urandom_range(0, 2) != 0);
            ordy   = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 24) == 0) begin
                do_redir = 1;
                redir_to = 32'($urandom_range(0, 1023)) << 2;
            end
            cycle();
        end
        quiesce();
        check_eq("t7_progress", {31'b0, (n_out - outs0) > 50}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit (errors=%0d checks=%0d)", errs, checks);
        $fatal(1);
    end

endmodule
